// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory responder.
//            Holds the responder FSM state encoding, the latency counter
//            width, and the all-zero data word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latency counter width; wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int          CNT_W     = 4;
    localparam logic [31:0] WORD_ZERO = 32'h0;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Word-addressed data storage, ADDR_WORDS x 32 bits. One
//            synchronous write port and one asynchronous read port that
//            share a single word index. Contents are not reset.
// Ports    : clk   - clock, write happens on the rising edge
//            we    - write enable
//            idx   - word index, shared by the read and write ports
//            wdata - write data
//            rdata - combinational read data at idx
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int ADDR_WORDS = 256,
    localparam int IDX_W     = $clog2(ADDR_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [ADDR_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Fixed-latency load/store responder in front of a word array.
//            A request is accepted in IDLE, waits LATENCY-1 cycles in WAIT
//            (skipped when LATENCY is 1), and completes with a one-cycle
//            resp_valid pulse in RESP. The array access happens on the edge
//            that enters RESP, so a reset before that edge drops the request
//            without touching memory.
// Config   : DMEM_ALIGN_CHECK_EN - when defined, requests with
//            req_addr[1:0] != 0 do not write, return zero data and raise
//            resp_err. When undefined, the low address bits are ignored.
// Ports    : clk        - clock
//            rstb       - synchronous active-high reset
//            req_valid  - request present
//            req_ready  - responder idle, request accepted this cycle
//            req_we     - 1 = store, 0 = load
//            req_addr   - byte address
//            req_wdata  - store data
//            resp_valid - one-cycle completion pulse
//            resp_rdata - load data (0 for stores and misaligned accesses)
//            resp_err   - misaligned-access flag
//            busy       - transaction in flight (WAIT or RESP)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int ADDR_WORDS = 256
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int               IDX_W    = $clog2(ADDR_WORDS);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // Captured request
    logic             r_we;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_misalign;

    // Output registers
    logic             r_resp_valid;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_err;

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_misalign_in;
    logic             w_op_we;
    logic [IDX_W-1:0] w_op_idx;
    logic [31:0]      w_op_wdata;
    logic             w_op_misalign;
    logic             w_mem_we;
    logic [31:0]      w_mem_rdata;
    logic             w_unused_addr;

    assign w_accept = (r_state == IDLE) && req_valid;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign_in = (req_addr[1:0] != 2'b00);
`else
    assign w_misalign_in = 1'b0;
`endif

    // Upper address bits wrap away; low bits only matter with the align check.
    assign w_unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

    // RESP is entered either from WAIT on the last count, or straight from
    // IDLE on the accept edge when LATENCY is 1.
    assign w_enter_resp = ((r_state == WAIT) && (r_cnt == CNT_W'(1))) ||
                          (w_accept && (LATENCY == 1));

    // When entering RESP directly from IDLE the captured registers are not
    // loaded yet, so the operation is taken from the live request instead.
    assign w_op_we       = (r_state == IDLE) ? req_we                   : r_we;
    assign w_op_idx      = (r_state == IDLE) ? req_addr[IDX_W+1:2]      : r_idx;
    assign w_op_wdata    = (r_state == IDLE) ? req_wdata                : r_wdata;
    assign w_op_misalign = (r_state == IDLE) ? w_misalign_in            : r_misalign;

    assign w_mem_we = w_enter_resp && w_op_we && !w_op_misalign && !rstb;

    dmem_array #(
        .ADDR_WORDS (ADDR_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (w_mem_we),
        .idx   (w_op_idx),
        .wdata (w_op_wdata),
        .rdata (w_mem_rdata)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= LOAD_CNT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_idx      <= req_addr[IDX_W+1:2];
            r_wdata    <= req_wdata;
            r_misalign <= w_misalign_in;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        req_ready = (r_state == IDLE);
        busy      = (r_state == WAIT) || (r_state == RESP);
    end

    // Response registers load on the RESP-entry edge so they line up with the
    // RESP state; resp_rdata holds its value between responses.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= WORD_ZERO;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_enter_resp;
            if (w_enter_resp) begin
                r_resp_rdata <= (w_op_we || w_op_misalign) ? WORD_ZERO : w_mem_rdata;
                r_resp_err   <= w_op_misalign;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001: The block SHALL have parameter LATENCY, default 2. It is the number of cycles from the request-accept edge to the resp_valid cycle. Legal range is 1..15.
- REQ-002: The block SHALL have parameter ADDR_WORDS, default 256. It is the storage depth in 32-bit words and SHALL be a power of two.
- REQ-003: Port clk, input, 1 bit: the single clock. All state updates occur on its rising edge.
- REQ-004: Port rstb, input, 1 bit: synchronous, active-high reset.
- REQ-005: Port req_valid, input, 1 bit: the pipeline presents a load or store request.
- REQ-006: Port req_ready, output, 1 bit: the responder can accept a request this cycle.
- REQ-007: Port req_we, input, 1 bit: 1 = store, 0 = load.
- REQ-008: Port req_addr, input, 32 bits: byte address, driven from the ALU result.
- REQ-009: Port req_wdata, input, 32 bits: store data, driven from the register-B read data.
- REQ-010: Port resp_valid, output, 1 bit: a one-cycle completion pulse for every accepted request.
- REQ-011: Port resp_rdata, output, 32 bits: load data, valid while resp_valid is 1.
- REQ-012: Port resp_err, output, 1 bit: misaligned-access flag, valid while resp_valid is 1.
- REQ-013: Port busy, output, 1 bit: 1 when state is WAIT or RESP.

Function
- REQ-014: The FSM SHALL have three states: IDLE, WAIT and RESP.
- REQ-015: req_ready SHALL be combinational and equal to (state == IDLE).
- REQ-016: In IDLE, when req_valid is 1, the block SHALL accept the request on that edge and register req_we, req_addr and req_wdata. It SHALL then load the down-counter with LATENCY-1.
  - Next state is WAIT.
  - If LATENCY is 1, next state is RESP.
- REQ-017: In WAIT, the counter SHALL decrement each cycle. On the edge where the counter equals 1, the FSM SHALL move to RESP.
- REQ-018: The block SHALL perform the array access on the edge that enters RESP.
  - Store: write the registered data to the array.
  - Load: register the array word into resp_rdata.
- REQ-019: In RESP, resp_valid SHALL be 1 for exactly one cycle. Next state is IDLE unconditionally; there is no response backpressure.
- REQ-020: resp_valid SHALL assert exactly LATENCY cycles after the accept edge. Sustained throughput is one request per LATENCY+1 cycles.
- REQ-021: A store response SHALL drive resp_rdata to 0.
- REQ-022: Outside RESP, resp_rdata SHALL hold its last value and resp_valid SHALL be 0.
- REQ-023: The word index SHALL be req_addr[log2(ADDR_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*ADDR_WORDS.
- REQ-024: A load issued after a store to the same word SHALL return the stored value.
- REQ-025: req_valid in WAIT or RESP SHALL be ignored. The requester must hold the request until req_ready is 1.

Reset
- REQ-026: While rstb is 1 at a clock edge, the block SHALL reset to:
  - state = IDLE
  - counter = 0
  - resp_valid = 0
  - resp_rdata = 0
  - resp_err = 0
  - busy = 0
- REQ-027: After reset, req_ready SHALL be 1.
- REQ-028: Reset during WAIT or RESP SHALL abort the transaction with no response. A store not yet committed SHALL NOT be written.
- REQ-029: Reset SHALL NOT clear the array contents.

Configuration
- REQ-030: The block SHALL support the macro DMEM_ALIGN_CHECK_EN.
- REQ-031: With DMEM_ALIGN_CHECK_EN defined, an accepted request with req_addr[1:0] != 0 SHALL behave as follows:
  - It follows the normal latency.
  - It performs no array write.
  - Its response has resp_rdata = 0 and resp_err = 1.
- REQ-032: With DMEM_ALIGN_CHECK_EN defined, aligned requests SHALL have resp_err = 0.
- REQ-033: Without DMEM_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and resp_err SHALL be tied to 0.

Structure
- REQ-034: A shared package dmem_pkg SHALL hold:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the constant CNT_W = 4;
  - the constant WORD_ZERO = 32'h0.
- REQ-035: Storage SHALL live in one sub-module, dmem_array, with a synchronous write port and an asynchronous read port. The FSM, counter and output registers SHALL live in dmem_responder.

Verification
- REQ-036: Store then load at LATENCY = 2:
  - Stimulus: store 0xDEADBEEF to 0x10, then load 0x10.
  - Each resp_valid SHALL occur 2 cycles after its accept.
  - Load resp_rdata = 0xDEADBEEF; store resp_rdata = 0.
- REQ-037: Back-to-back requests:
  - Stimulus: hold req_valid = 1 continuously.
  - Accepts SHALL occur every 3 cycles (LATENCY = 2).
  - req_ready SHALL be 0 in the two cycles after each accept.
- REQ-038: Address wrap:
  - Stimulus: ADDR_WORDS = 256, store 0x12345678 to 0x400, load 0x000.
  - The load SHALL return 0x12345678.
- REQ-039: Reset mid-store:
  - Stimulus: store 0xAAAA5555 to 0x20, assert rstb in the WAIT cycle, then load 0x20.
  - The store SHALL produce no resp_valid.
  - The load SHALL return the prior contents of 0x20.
- REQ-040: Misaligned access with DMEM_ALIGN_CHECK_EN defined:
  - Stimulus: store to 0x22.
  - Response SHALL be resp_err = 1, resp_rdata = 0.
  - A later load of 0x20 SHALL show the word unchanged.
- REQ-041: Minimum latency:
  - Stimulus: LATENCY = 1, load 0x04.
  - resp_valid SHALL assert on the cycle immediately after the accept.
  - busy SHALL be 1 only in that response cycle.
